// File: rtl/imem_boot_loader_if.sv
// Byte-receiver-to-loader bus plus the loader's memory-write and core-control outputs.
// Latency: none (wires only).
// Backpressure: none; rx_valid is a strobe and the loader always accepts.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 6
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_wr_addr;
    logic [15:0]       imem_wr_data;
    logic              core_rst;
    logic              done;
    logic              error;

    // Byte source side: drives the receive strobe and observes loader outputs.
    modport master (
        output rx_valid, rx_byte,
        input  imem_wr_en, imem_wr_addr, imem_wr_data, core_rst, done, error
    );

    // Loader side.
    modport slave (
        input  rx_valid, rx_byte,
        output imem_wr_en, imem_wr_addr, imem_wr_data, core_rst, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Frame-checked serial loader: sync, count, 2N data bytes, XOR checksum -> imem writes, core release.
// Latency: every output is registered; write strobe / done / error appear one cycle after the causing byte.
// Backpressure: none; one byte per cycle is absorbed, writes at most every other cycle.
module imem_boot_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         DEPTH     = 64,
    parameter int         ADDR_W    = 6,
    parameter int         TIMEOUT   = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_boot_loader_if.slave    bus
);
    localparam int               IDLE_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] TO_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [7:0]       DEPTH_B = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [IDLE_W-1:0] idle_cnt;
    logic [7:0]        n_words;
    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        hi_byte;
    logic [7:0]        chk;

    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [15:0]       wr_data_r;
    logic              core_rst_r;
    logic              done_r;
    logic              error_r;

    logic              in_frame;
    logic              timeout;
    logic              last_word;
    logic              bad_count;

    logic              wr_en_nxt;
    logic              core_rst_nxt;
    logic              done_nxt;
    logic              error_nxt;

    assign in_frame  = (state == S_COUNT) || (state == S_DATA_HI) ||
                       (state == S_DATA_LO) || (state == S_CHECK);
    // A byte landing on the final idle cycle wins over the timeout.
    assign timeout   = in_frame && !bus.rx_valid && (idle_cnt == TO_LAST);
    assign last_word = ((8'(word_addr) + 8'd1) == n_words);
    assign bad_count = (bus.rx_byte == 8'd0) || (bus.rx_byte > DEPTH_B);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; timeout overrides any in-frame state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                if (bus.rx_valid) state_nxt = bad_count ? S_ERROR : S_DATA_HI;
            end
            S_DATA_HI: begin
                if (bus.rx_valid) state_nxt = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (bus.rx_valid) state_nxt = last_word ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                if (bus.rx_valid) state_nxt = (bus.rx_byte == chk) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            S_ERROR: begin
                if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) state_nxt = S_COUNT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (timeout) state_nxt = S_ERROR;
    end

    // Output decode: values the output registers take at the next edge.
    always_comb begin
        wr_en_nxt    = (state == S_DATA_LO) && bus.rx_valid;
        done_nxt     = (state_nxt == S_DONE);
        core_rst_nxt = (state_nxt != S_DONE);
        error_nxt    = (state_nxt == S_ERROR);
    end

    // Datapath: idle counter, word assembly, checksum and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt   <= '0;
            n_words    <= 8'd0;
            word_addr  <= '0;
            hi_byte    <= 8'd0;
            chk        <= 8'd0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= 16'd0;
            core_rst_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            if (in_frame && !bus.rx_valid) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end

            if (bus.rx_valid) begin
                case (state)
                    S_COUNT: begin
                        if (!bad_count) begin
                            n_words   <= bus.rx_byte;
                            word_addr <= '0;
                            chk       <= 8'd0;
                        end
                    end
                    S_DATA_HI: begin
                        hi_byte <= bus.rx_byte;
                        chk     <= chk ^ bus.rx_byte;
                    end
                    S_DATA_LO: begin
                        chk       <= chk ^ bus.rx_byte;
                        wr_addr_r <= word_addr;
                        wr_data_r <= {hi_byte, bus.rx_byte};
                        // Hold at the final address so it never wraps.
                        if (!last_word) word_addr <= word_addr + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            wr_en_r    <= wr_en_nxt;
            core_rst_r <= core_rst_nxt;
            done_r     <= done_nxt;
            error_r    <= error_nxt;
        end
    end

    assign bus.imem_wr_en   = wr_en_r;
    assign bus.imem_wr_addr = wr_addr_r;
    assign bus.imem_wr_data = wr_data_r;
    assign bus.core_rst     = core_rst_r;
    assign bus.done         = done_r;
    assign bus.error        = error_r;
endmodule
